// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared types and helpers for the bit-serial arithmetic blocks.
//   state_t : controller states (IDLE, RUN, DONE)
//   CNT_W   : bit-position counter width for an N-bit operand, max(1, clog2(N))
// -----------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int CNT_W(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// -----------------------------------------------------------------------------
// sub_bit_cell
// Combinational single-bit full-adder cell used for subtraction: the caller
// supplies the inverted subtrahend bit, so s/c' realise a - b with borrow
// carried as an inverted carry.
// Ports:
//   i_a  : minuend bit
//   i_nb : inverted subtrahend bit
//   i_c  : carry in (inverted borrow)
//   o_s  : difference bit
//   o_c  : carry out (inverted borrow out)
// -----------------------------------------------------------------------------
module sub_bit_cell (
  input  logic i_a,
  input  logic i_nb,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_nb ^ i_c;
  assign o_c = (i_a & i_nb) | (i_a & i_c) | (i_nb & i_c);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial N-bit subtractor: diff = a - b - bin (mod 2^N), LSB first, one
// bit per clock through a single sub_bit_cell. A result is available N+1
// cycles after the operands are accepted; a start in the DONE cycle is taken
// immediately, giving back-to-back operations every N+1 cycles.
// Optional feature: define SERIAL_SUB_OVF_EN to add o_ovf, the two's-complement
// signed overflow of the subtraction.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   i_start : request, accepted only while o_ready=1
//   i_a     : minuend (N bits), sampled on accept
//   i_b     : subtrahend (N bits), sampled on accept
//   i_bin   : borrow in, sampled on accept
//   o_ready : block accepts i_start this cycle
//   o_busy  : operation in progress
//   o_done  : one-cycle pulse, o_diff/o_bout newly updated
//   o_diff  : result, held until the next completion
//   o_bout  : borrow out, 1 iff a < b + bin (unsigned)
//   o_ovf   : signed overflow (only with SERIAL_SUB_OVF_EN)
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int N = 100
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bin,
  output logic         o_ready,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_diff,
  output logic         o_bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         o_ovf
`endif
);

  localparam int            CW       = CNT_W(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t         r_state;
  state_t         w_next;
  logic           w_accept;
  logic           w_last;

  logic [N-1:0]   r_sreg_a;
  logic [N-1:0]   r_sreg_b;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;

  logic           w_s;
  logic           w_cout;
  logic [N-1:0]   w_res_next;

  logic           r_ready;
  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_diff;
  logic           r_bout;

  assign w_last = (r_cnt == LAST_CNT);

  sub_bit_cell u_cell (
    .i_a  (r_sreg_a[0]),
    .i_nb (r_sreg_b[0]),
    .i_c  (r_carry),
    .o_s  (w_s),
    .o_c  (w_cout)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and accept decode
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = RUN;
        end
      end
      DONE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand shifters, carry and bit counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg_a <= '0;
      r_sreg_b <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      // Subtraction as a + ~b + ~bin: inverted subtrahend, carry seeded with ~bin.
      r_sreg_a <= i_a;
      r_sreg_b <= ~i_b;
      r_carry  <= ~i_bin;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_sreg_a <= r_sreg_a >> 1;
      r_sreg_b <= r_sreg_b >> 1;
      r_carry  <= w_cout;
      r_cnt    <= r_cnt + CW'(1);
    end else begin
      r_sreg_a <= r_sreg_a;
      r_sreg_b <= r_sreg_b;
      r_carry  <= r_carry;
      r_cnt    <= r_cnt;
    end
  end

  // Result register: each new bit enters at the MSB. Its LSB would be shifted
  // out on the final bit anyway, so only N-1 bits are stored and the final
  // word is assembled from the current cell output.
  generate
    if (N == 1) begin : g_res1
      assign w_res_next = w_s;
    end else begin : g_resn
      logic [N-2:0] r_res;

      // Partial-result shifter
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_res <= '0;
        end else if (w_accept) begin
          r_res <= '0;
        end else if (r_state == RUN) begin
          r_res <= w_res_next[N-1:1];
        end else begin
          r_res <= r_res;
        end
      end

      assign w_res_next = {w_s, r_res};
    end
  endgenerate

  // Handshake outputs, registered from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_next != RUN);
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
    end
  end

  // Result outputs, loaded on the last RUN cycle (i.e. on entry to DONE)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_diff <= w_res_next;
      r_bout <= ~w_cout;
    end else begin
      r_diff <= r_diff;
      r_bout <= r_bout;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Operand sign capture and overflow flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= i_a[N-1];
      r_b_msb <= i_b[N-1];
      r_ovf   <= r_ovf;
    end else if ((r_state == RUN) && w_last) begin
      // Last cell output is the result sign bit.
      r_a_msb <= r_a_msb;
      r_b_msb <= r_b_msb;
      r_ovf   <= (r_a_msb != r_b_msb) && (w_s != r_a_msb);
    end else begin
      r_a_msb <= r_a_msb;
      r_b_msb <= r_b_msb;
      r_ovf   <= r_ovf;
    end
  end

  assign o_ovf = r_ovf;
`endif

  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_diff  = r_diff;
  assign o_bout  = r_bout;

endmodule
